// File: rtl/si5338_pkg.sv
// -----------------------------------------------------------------------------
// si5338_pkg
// Shared definitions for the Si5338 configuration sequencer:
//   - SI5338_I2C_ADDR : 7-bit I2C slave address of the Si5338
//   - ROM_W           : width of one table entry, {reg_addr[15:8], reg_data[7:0]}
//   - state_t         : sequencer FSM state encoding
//   - rom_entry()     : the fixed register/value table, indexed by entry number
// -----------------------------------------------------------------------------
package si5338_pkg;

    localparam logic [6:0] SI5338_I2C_ADDR = 7'h70;
    localparam int         ROM_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_REQ   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_FIN   = 3'd6,
        ST_FAIL  = 3'd7
    } state_t;

    // Bring-up order: gate outputs, pause LOL, program output dividers,
    // soft reset, then release the outputs again.
    function automatic logic [ROM_W-1:0] rom_entry(input logic [7:0] idx);
        case (idx)
            8'd0:    return 16'hE610;   // reg 230: disable all outputs
            8'd1:    return 16'hF1E5;   // reg 241: pause LOL
            8'd2:    return 16'h1FC0;   // reg 31 : CLK0 divider config
            8'd3:    return 16'h20C0;   // reg 32 : CLK1 divider config
            8'd4:    return 16'h21C0;   // reg 33 : CLK2 divider config
            8'd5:    return 16'h22C0;   // reg 34 : CLK3 divider config
            8'd6:    return 16'hF602;   // reg 246: soft reset
            8'd7:    return 16'hE600;   // reg 230: enable all outputs
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/si5338_cfg_sequencer_if.sv
// -----------------------------------------------------------------------------
// si5338_cfg_sequencer_if
// Byte-write request channel between the configuration sequencer and the
// I2C master.
//   oREQ         : write request (sequencer -> master)
//   oSLAVE_ADDR  : 7-bit slave address
//   oREG_ADDR    : register address of the current entry
//   oREG_DATA    : value to write
//   iACK         : master accepted the request
//   iXFER_DONE   : one-cycle transfer-complete pulse
//   iXFER_NACK   : qualifies iXFER_DONE, slave NACKed
// master modport = sequencer side, slave modport = I2C master side.
// -----------------------------------------------------------------------------
interface si5338_cfg_sequencer_if;

    logic       oREQ;
    logic [6:0] oSLAVE_ADDR;
    logic [7:0] oREG_ADDR;
    logic [7:0] oREG_DATA;
    logic       iACK;
    logic       iXFER_DONE;
    logic       iXFER_NACK;

    modport master (
        output oREQ, oSLAVE_ADDR, oREG_ADDR, oREG_DATA,
        input  iACK, iXFER_DONE, iXFER_NACK
    );

    modport slave (
        input  oREQ, oSLAVE_ADDR, oREG_ADDR, oREG_DATA,
        output iACK, iXFER_DONE, iXFER_NACK
    );

endinterface

// File: rtl/si5338_reg_rom.sv
// -----------------------------------------------------------------------------
// si5338_reg_rom
// Synchronous-read register table, NUM_REGS deep, one cycle read latency.
//   iCLK    : clock
//   iRST_n  : asynchronous active-low reset
//   i_addr  : entry index
//   o_data  : {reg_addr, reg_data} of the entry addressed on the previous cycle;
//             indices at or beyond NUM_REGS read as zero
// -----------------------------------------------------------------------------
module si5338_reg_rom
    import si5338_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic [7:0]       i_addr,
    output logic [ROM_W-1:0] o_data
);

    logic [ROM_W-1:0] r_data;

    // NOTE: the table itself is constant decode logic, not a RAM, so there is
    // nothing to initialise; only the read register holds state.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_data <= '0;
        end else if ({1'b0, i_addr} < 9'(NUM_REGS)) begin
            r_data <= rom_entry(i_addr);
        end else begin
            r_data <= '0;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/si5338_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// si5338_cfg_sequencer
// On a one-cycle start pulse, walks the Si5338 register table and issues one
// I2C byte-write per entry, retrying an entry on NACK or timeout.
//   iCLK, iRST_n : clock, asynchronous active-low reset
//   iSTART       : one-cycle start pulse, ignored while busy
//   i2c          : request channel to the I2C master (master modport)
//   oBUSY        : sequence in progress
//   oDONE        : last sequence completed cleanly (level)
//   oERR         : last sequence aborted (level)
//   oERR_IDX     : table index of the entry that exhausted its retries
// Parameters:
//   NUM_REGS       : table entries, 1..256
//   MAX_RETRY      : extra attempts per entry after NACK/timeout
//   TIMEOUT_CYCLES : cycles from request acceptance to iXFER_DONE, 16-bit
// -----------------------------------------------------------------------------
module si5338_cfg_sequencer
    import si5338_pkg::*;
#(
    parameter int NUM_REGS       = 8,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   iCLK,
    input  logic                   iRST_n,
    input  logic                   iSTART,
    si5338_cfg_sequencer_if.master i2c,
    output logic                   oBUSY,
    output logic                   oDONE,
    output logic                   oERR,
    output logic [7:0]             oERR_IDX
);

    localparam logic [7:0]  LAST_IDX    = 8'(NUM_REGS - 1);
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    state_t           r_state,    w_state_nxt;
    logic [7:0]       r_idx,      w_idx_nxt;
    logic [7:0]       r_retry,    w_retry_nxt;
    logic [15:0]      r_tmo,      w_tmo_nxt;
    logic [7:0]       r_reg_addr, w_reg_addr_nxt;
    logic [7:0]       r_reg_data, w_reg_data_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;
    logic             r_err,      w_err_nxt;
    logic [7:0]       r_err_idx,  w_err_idx_nxt;
    logic             r_req;
    logic             w_xfer_ok;
    logic             w_xfer_bad;
    logic [ROM_W-1:0] w_rom_data;

    si5338_reg_rom #(
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .i_addr (r_idx),
        .o_data (w_rom_data)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_retry_nxt    = r_retry;
        w_tmo_nxt      = r_tmo;
        w_reg_addr_nxt = r_reg_addr;
        w_reg_data_nxt = r_reg_data;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_err_nxt      = r_err;
        w_err_idx_nxt  = r_err_idx;
        w_xfer_ok      = 1'b0;
        w_xfer_bad     = 1'b0;

        case (r_state)
            ST_IDLE, ST_FIN, ST_FAIL: begin
                if (iSTART) begin
                    w_idx_nxt   = '0;
                    w_retry_nxt = '0;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_reg_addr_nxt = w_rom_data[15:8];
                w_reg_data_nxt = w_rom_data[7:0];
                w_state_nxt    = ST_REQ;
            end
            ST_REQ: begin
                if (i2c.iACK) begin
                    w_tmo_nxt = '0;
                    // A master that finishes in the accepting cycle is
                    // resolved here rather than waiting for a done that
                    // already went by.
                    if (i2c.iXFER_DONE) begin
                        w_xfer_ok  = ~i2c.iXFER_NACK;
                        w_xfer_bad = i2c.iXFER_NACK;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_tmo_nxt = r_tmo + 16'd1;
                if (i2c.iXFER_DONE) begin
                    // done takes priority over a coincident timeout
                    w_xfer_ok  = ~i2c.iXFER_NACK;
                    w_xfer_bad = i2c.iXFER_NACK;
                end else if (r_tmo == TMO_LAST) begin
                    w_xfer_bad = 1'b1;
                end
            end
            ST_NEXT: begin
                w_retry_nxt = '0;
                if (r_idx == LAST_IDX) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_FIN;
                end else begin
                    w_idx_nxt   = r_idx + 8'd1;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_xfer_ok) begin
            w_state_nxt = ST_NEXT;
        end else if (w_xfer_bad) begin
            if (r_retry < RETRY_LIMIT) begin
                w_retry_nxt = r_retry + 8'd1;
                w_state_nxt = ST_REQ;
            end else begin
                w_busy_nxt    = 1'b0;
                w_err_nxt     = 1'b1;
                w_err_idx_nxt = r_idx;
                w_state_nxt   = ST_FAIL;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples the values
    // that existed before the edge, independent of statement order.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_retry    <= '0;
            r_tmo      <= '0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_idx  <= '0;
            r_req      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_retry    <= w_retry_nxt;
            r_tmo      <= w_tmo_nxt;
            r_reg_addr <= w_reg_addr_nxt;
            r_reg_data <= w_reg_data_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_idx  <= w_err_idx_nxt;
            // registered so the request line is glitch-free toward the master
            r_req      <= (w_state_nxt == ST_REQ);
        end
    end

    assign i2c.oREQ        = r_req;
    assign i2c.oSLAVE_ADDR = SI5338_I2C_ADDR;
    assign i2c.oREG_ADDR   = r_reg_addr;
    assign i2c.oREG_DATA   = r_reg_data;
    assign oBUSY           = r_busy;
    assign oDONE           = r_done;
    assign oERR            = r_err;
    assign oERR_IDX        = r_err_idx;

endmodule

// File: tb/tb_si5338_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_si5338_cfg_sequencer
// Directed bench for si5338_cfg_sequencer. A behavioural I2C master acks each
// request on the cycle it appears and returns done DONE_LAT cycles later; it
// can NACK a chosen entry a set number of times, never return done, or return
// done together with the ack. Every accepted request is logged and compared
// against the expected register table.
// -----------------------------------------------------------------------------
module tb_si5338_cfg_sequencer;

    localparam int NUM_REGS = 8;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT = 20;
    localparam int DONE_LAT = 10;
    // REQ cycle + TIMEOUT wait cycles between two accepted attempts
    localparam int RETRY_SPACING = TIMEOUT + 1;

    localparam logic [15:0] EXP_TBL [NUM_REGS] = '{
        16'hE610, 16'hF1E5, 16'h1FC0, 16'h20C0,
        16'h21C0, 16'h22C0, 16'hF602, 16'hE600
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, err;
    logic [7:0] err_idx;

    si5338_cfg_sequencer_if bus();

    si5338_cfg_sequencer #(
        .NUM_REGS       (NUM_REGS),
        .MAX_RETRY      (MAX_RETRY),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .iCLK     (clk),
        .iRST_n   (rst_n),
        .iSTART   (start),
        .i2c      (bus),
        .oBUSY    (busy),
        .oDONE    (done),
        .oERR     (err),
        .oERR_IDX (err_idx)
    );

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    logic [15:0] req_log [$];
    int          req_time [$];
    logic [7:0]  nack_addr = 8'h00;
    logic [7:0]  nack_data = 8'h00;
    int          nack_left = 0;
    bit          hang_all = 1'b0;
    bit          same_cycle = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural I2C master, driven on the falling edge.
    initial begin : responder
        int   cnt;
        logic pend_nack;
        logic nack;
        cnt = 0;
        pend_nack = 1'b0;
        bus.iACK = 1'b0;
        bus.iXFER_DONE = 1'b0;
        bus.iXFER_NACK = 1'b0;
        forever begin
            @(negedge clk);
            bus.iACK = 1'b0;
            bus.iXFER_DONE = 1'b0;
            bus.iXFER_NACK = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.iXFER_DONE = 1'b1;
                    bus.iXFER_NACK = pend_nack;
                end
            end else if (bus.oREQ) begin
                req_log.push_back({bus.oREG_ADDR, bus.oREG_DATA});
                req_time.push_back(cyc);
                nack = 1'b0;
                if (nack_left > 0 && bus.oREG_ADDR == nack_addr && bus.oREG_DATA == nack_data) begin
                    nack = 1'b1;
                    nack_left--;
                end
                bus.iACK = 1'b1;
                if (same_cycle) begin
                    bus.iXFER_DONE = 1'b1;
                    bus.iXFER_NACK = nack;
                end else if (!hang_all) begin
                    cnt = DONE_LAT;
                    pend_nack = nack;
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (bus.oREQ !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.oREQ); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
        total_cnt++; if (err_idx !== 8'h00) $display("FAIL reset_err_idx: got %h want 00", err_idx); else pass_cnt++;
        total_cnt++; if (bus.oREG_ADDR !== 8'h00) $display("FAIL reset_reg_addr: got %h want 00", bus.oREG_ADDR); else pass_cnt++;
        total_cnt++; if (bus.oREG_DATA !== 8'h00) $display("FAIL reset_reg_data: got %h want 00", bus.oREG_DATA); else pass_cnt++;
        total_cnt++; if (bus.oSLAVE_ADDR !== 7'h70) $display("FAIL slave_addr: got %h want 70", bus.oSLAVE_ADDR); else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || bus.oREQ !== 1'b0) $display("FAIL idle_after_reset: busy=%b req=%b want 0 0", busy, bus.oREQ); else pass_cnt++;
    endtask

    task automatic test_basic();
        bit ok;
        req_log.delete();
        req_time.delete();
        pulse_start();
        total_cnt++; if (busy !== 1'b1 || bus.oREQ !== 1'b0) $display("FAIL lat_fetch: busy=%b req=%b want 1 0", busy, bus.oREQ); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.oREQ !== 1'b0) $display("FAIL lat_load: req=%b want 0", bus.oREQ); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.oREQ !== 1'b1) $display("FAIL lat_req: req=%b want 1", bus.oREQ); else pass_cnt++;
        total_cnt++; if ({bus.oREG_ADDR, bus.oREG_DATA} !== 16'hE610) $display("FAIL first_entry: got %h want e610", {bus.oREG_ADDR, bus.oREG_DATA}); else pass_cnt++;
        wait_idle(400, ok);
        total_cnt++; if (!ok) $display("FAIL basic_timeout: busy=%b want 0", busy); else pass_cnt++;
        total_cnt++; if (req_log.size() != NUM_REGS) $display("FAIL basic_count: got %0d want %0d", req_log.size(), NUM_REGS); else pass_cnt++;
        for (int i = 0; i < NUM_REGS && i < req_log.size(); i++) begin
            total_cnt++; if (req_log[i] !== EXP_TBL[i]) $display("FAIL basic_entry%0d: got %h want %h", i, req_log[i], EXP_TBL[i]); else pass_cnt++;
        end
        total_cnt++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) $display("FAIL basic_status: done=%b err=%b busy=%b want 1 0 0", done, err, busy); else pass_cnt++;
    endtask

    task automatic test_retry();
        bit ok;
        int exp_idx [$];
        exp_idx = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 7};
        req_log.delete();
        nack_addr = 8'h1F;
        nack_data = 8'hC0;
        nack_left = 2;
        pulse_start();
        wait_idle(500, ok);
        total_cnt++; if (!ok) $display("FAIL retry_timeout: busy=%b want 0", busy); else pass_cnt++;
        total_cnt++; if (req_log.size() != exp_idx.size()) $display("FAIL retry_count: got %0d want %0d", req_log.size(), exp_idx.size()); else pass_cnt++;
        for (int i = 0; i < exp_idx.size() && i < req_log.size(); i++) begin
            total_cnt++; if (req_log[i] !== EXP_TBL[exp_idx[i]]) $display("FAIL retry_entry%0d: got %h want %h", i, req_log[i], EXP_TBL[exp_idx[i]]); else pass_cnt++;
        end
        total_cnt++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL retry_status: done=%b err=%b want 1 0", done, err); else pass_cnt++;
    endtask

    task automatic test_fail();
        bit ok;
        int exp_idx [$];
        exp_idx = '{0, 1, 2, 3, 4, 5, 5, 5, 5};
        req_log.delete();
        nack_addr = 8'h22;
        nack_data = 8'hC0;
        nack_left = 4;
        pulse_start();
        wait_idle(500, ok);
        total_cnt++; if (!ok) $display("FAIL fail_timeout: busy=%b want 0", busy); else pass_cnt++;
        repeat (30) @(negedge clk);
        total_cnt++; if (req_log.size() != exp_idx.size()) $display("FAIL fail_count: got %0d want %0d", req_log.size(), exp_idx.size()); else pass_cnt++;
        for (int i = 0; i < exp_idx.size() && i < req_log.size(); i++) begin
            total_cnt++; if (req_log[i] !== EXP_TBL[exp_idx[i]]) $display("FAIL fail_entry%0d: got %h want %h", i, req_log[i], EXP_TBL[exp_idx[i]]); else pass_cnt++;
        end
        total_cnt++; if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) $display("FAIL fail_status: err=%b done=%b busy=%b want 1 0 0", err, done, busy); else pass_cnt++;
        total_cnt++; if (err_idx !== 8'd5) $display("FAIL fail_err_idx: got %0d want 5", err_idx); else pass_cnt++;
        nack_left = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        req_log.delete();
        req_time.delete();
        hang_all = 1'b1;
        pulse_start();
        wait_idle(300, ok);
        total_cnt++; if (!ok) $display("FAIL tmo_timeout: busy=%b want 0", busy); else pass_cnt++;
        total_cnt++; if (req_log.size() != MAX_RETRY + 1) $display("FAIL tmo_count: got %0d want %0d", req_log.size(), MAX_RETRY + 1); else pass_cnt++;
        for (int i = 0; i < req_log.size(); i++) begin
            total_cnt++; if (req_log[i] !== EXP_TBL[0]) $display("FAIL tmo_entry%0d: got %h want %h", i, req_log[i], EXP_TBL[0]); else pass_cnt++;
        end
        for (int i = 1; i < req_time.size(); i++) begin
            total_cnt++; if (req_time[i] - req_time[i-1] != RETRY_SPACING) $display("FAIL tmo_spacing%0d: got %0d want %0d", i, req_time[i] - req_time[i-1], RETRY_SPACING); else pass_cnt++;
        end
        total_cnt++; if (err !== 1'b1 || err_idx !== 8'd0) $display("FAIL tmo_status: err=%b idx=%0d want 1 0", err, err_idx); else pass_cnt++;
        hang_all = 1'b0;
    endtask

    task automatic test_start_ignored();
        bit ok;
        req_log.delete();
        pulse_start();
        wait_log(3, 100, ok);
        total_cnt++; if (!ok) $display("FAIL ign_progress: got %0d reqs want 3", req_log.size()); else pass_cnt++;
        pulse_start();
        wait_idle(400, ok);
        total_cnt++; if (!ok) $display("FAIL ign_timeout: busy=%b want 0", busy); else pass_cnt++;
        total_cnt++; if (req_log.size() != NUM_REGS) $display("FAIL ign_count: got %0d want %0d", req_log.size(), NUM_REGS); else pass_cnt++;
        for (int i = 0; i < NUM_REGS && i < req_log.size(); i++) begin
            total_cnt++; if (req_log[i] !== EXP_TBL[i]) $display("FAIL ign_entry%0d: got %h want %h", i, req_log[i], EXP_TBL[i]); else pass_cnt++;
        end
        total_cnt++; if (done !== 1'b1) $display("FAIL ign_done: got %b want 1", done); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        req_log.delete();
        pulse_start();
        wait_log(1, 50, ok);
        total_cnt++; if (!ok) $display("FAIL rst_progress: got %0d reqs want 1", req_log.size()); else pass_cnt++;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.oREQ !== 1'b0 || busy !== 1'b0) $display("FAIL rst_async: req=%b busy=%b want 0 0", bus.oREQ, busy); else pass_cnt++;
        total_cnt++; if (bus.oREG_ADDR !== 8'h00 || done !== 1'b0) $display("FAIL rst_async_regs: addr=%h done=%b want 00 0", bus.oREG_ADDR, done); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        total_cnt++; if (req_log.size() != 1 || busy !== 1'b0) $display("FAIL rst_quiet: reqs=%0d busy=%b want 1 0", req_log.size(), busy); else pass_cnt++;
        req_log.delete();
        pulse_start();
        wait_idle(400, ok);
        total_cnt++; if (!ok) $display("FAIL rst_restart_timeout: busy=%b want 0", busy); else pass_cnt++;
        total_cnt++; if (req_log.size() != NUM_REGS) $display("FAIL rst_restart_count: got %0d want %0d", req_log.size(), NUM_REGS); else pass_cnt++;
        for (int i = 0; i < NUM_REGS && i < req_log.size(); i++) begin
            total_cnt++; if (req_log[i] !== EXP_TBL[i]) $display("FAIL rst_restart_entry%0d: got %h want %h", i, req_log[i], EXP_TBL[i]); else pass_cnt++;
        end
        total_cnt++; if (done !== 1'b1) $display("FAIL rst_restart_done: got %b want 1", done); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        req_log.delete();
        same_cycle = 1'b1;
        pulse_start();
        wait_idle(200, ok);
        total_cnt++; if (!ok) $display("FAIL b2b_timeout: busy=%b want 0", busy); else pass_cnt++;
        total_cnt++; if (req_log.size() != NUM_REGS) $display("FAIL b2b_count: got %0d want %0d", req_log.size(), NUM_REGS); else pass_cnt++;
        for (int i = 0; i < NUM_REGS && i < req_log.size(); i++) begin
            total_cnt++; if (req_log[i] !== EXP_TBL[i]) $display("FAIL b2b_entry%0d: got %h want %h", i, req_log[i], EXP_TBL[i]); else pass_cnt++;
        end
        total_cnt++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL b2b_status: done=%b err=%b want 1 0", done, err); else pass_cnt++;
        same_cycle = 1'b0;
    endtask

    initial begin : main
        test_reset();
        test_basic();
        test_retry();
        test_fail();
        test_timeout();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/si5338_cfg_sequencer.md
Name: si5338_cfg_sequencer

Overview:
- Downstream consumer of the debounced button/trigger pulse in the si5338_controller path.
- On a one-cycle start pulse, walks a fixed table of Si5338 register/value pairs.
- Issues one I2C byte-write request per entry to the I2C master over a req/ack handshake, with per-entry retry and timeout.
- Reports busy, done and error status to the top level and LEDs.

Parameters:
- NUM_REGS, 8: number of table entries; legal range 1..256.
- MAX_RETRY, 3: extra attempts per entry after NACK/timeout; 0 means no retry.
- TIMEOUT_CYCLES, 50000: iCLK cycles allowed from request acceptance to iXFER_DONE; 16-bit range.

Ports:
- iCLK  in  1  system clock
- iRST_n  in  1  asynchronous active-low reset
- iSTART  in  1  one-cycle start pulse (debounced trigger)
- oREQ  out  1  write request to I2C master
- oSLAVE_ADDR  out  7  I2C slave address, constant SI5338_I2C_ADDR
- oREG_ADDR  out  8  Si5338 register address of current entry
- oREG_DATA  out  8  value to write
- iACK  in  1  I2C master accepted request
- iXFER_DONE  in  1  one-cycle transfer-complete pulse
- iXFER_NACK  in  1  qualifies iXFER_DONE: slave NACKed
- oBUSY  out  1  sequence in progress
- oDONE  out  1  level: last sequence completed cleanly
- oERR  out  1  level: last sequence aborted
- oERR_IDX  out  8  table index of failing entry

Behaviour:
- Reset (async, iRST_n low): state IDLE. oREQ=0, oREG_ADDR=0, oREG_DATA=0, oBUSY=0, oDONE=0, oERR=0, oERR_IDX=0; internal idx=0, retry_cnt=0, tmo_cnt=0. oSLAVE_ADDR is constant.
- Reset mid-operation: aborts immediately. No further oREQ. Outputs take their reset values.
- States: IDLE, FETCH, LOAD, REQ, WAIT, NEXT, FIN, FAIL.
- IDLE/FIN/FAIL, iSTART=1: idx<=0, retry_cnt<=0, oDONE<=0, oERR<=0, oBUSY<=1, go to FETCH.
- iSTART while oBUSY=1: ignored.
- FETCH: present idx to ROM. Go to LOAD.
- LOAD: ROM data valid (1-cycle ROM latency). Register {addr,data} into oREG_ADDR/oREG_DATA. Go to REQ.
- REQ: oREQ=1; address/data outputs stable. On iACK=1: oREQ<=0 next cycle, tmo_cnt<=0, go to WAIT.
- REQ, iACK=1 and iXFER_DONE=1 in the same cycle: evaluated as a completion this cycle, with the same outcome as WAIT.
- WAIT: tmo_cnt increments each cycle.
  - iXFER_DONE=1 and iXFER_NACK=0: go to NEXT.
  - iXFER_DONE=1 and iXFER_NACK=1, or tmo_cnt reaching TIMEOUT_CYCLES-1 without done: if retry_cnt<MAX_RETRY, retry_cnt++ and go to REQ with the same entry; else go to FAIL.
  - iXFER_DONE in the same cycle as timeout expiry: the done wins.
- NEXT: retry_cnt<=0. If idx==NUM_REGS-1, go to FIN; else idx++ and go to FETCH. idx is 8-bit and never wraps past NUM_REGS-1.
- FIN: oBUSY=0, oDONE=1. Stays until next iSTART.
- FAIL: oBUSY=0, oERR=1, oERR_IDX=idx. Stays until next iSTART.
- iXFER_DONE outside WAIT/REQ: ignored.
- Minimum per-entry latency, iSTART to first oREQ: 3 cycles (FETCH, LOAD, then oREQ asserted).

Decomposition:
- Package si5338_pkg:
  - SI5338_I2C_ADDR = 7'h70
  - state encoding constants
  - ROM entry width 16 (addr[15:8], data[7:0])
- Sub-module si5338_reg_rom (synchronous-read table, NUM_REGS deep, 1-cycle latency) instantiated inside the sequencer.

Test Plan:
- Reset released, iSTART pulse, master acks in 1 cycle and returns done/ACK 10 cycles later -> 8 oREQ pulses with the ROM addr/data in order; oDONE=1, oBUSY=0, oERR=0.
- Entry 2 NACKed twice then ACKed (MAX_RETRY=3) -> entry 2 requested 3 times with identical addr/data, entry 3 follows, oDONE=1.
- Entry 5 NACKed 4 times -> FAIL; oERR=1, oERR_IDX=5, no oREQ for entry 6.
- TIMEOUT_CYCLES=20, master never returns done on entry 0 -> retry after 20 cycles, 4 attempts total, then oERR=1, oERR_IDX=0.
- iSTART mid-sequence -> ignored, sequence unchanged. iRST_n low during WAIT -> oREQ=0, oBUSY=0 asynchronously. New iSTART after reset -> restart from idx 0.
- iACK and iXFER_DONE asserted in the same cycle on every entry -> sequence completes with no hang; oDONE=1.
